// File: rtl/pcie_rx_tlp_checker.sv
// Validates TLP framing/header of one AVST RX channel; forwards good beats, 1-cycle latency, no backpressure.
// Optional length-vs-beat-count check compiled in by PCIE_RX_LEN_CHECK_EN.
package pcie_rx_pkg;
   localparam int AVST_DWORD_LEN = 8;
   localparam int PCIE_MAX_LEN   = 1024;

   typedef struct packed {
      logic                          valid;
      logic                          sop;
      logic                          eop;
      logic [2:0]                    empty;
      logic [2:0]                    bar_range;
      logic [127:0]                  hdr;
      logic [AVST_DWORD_LEN*32-1:0]  data;
   } t_avst_pcie_rx;

   typedef struct packed {
      logic err_parity;
      logic err_cpl_timeout;
      logic err_cpl_status;
      logic err_unexp_cpl;
      logic err_fmttype;
      logic err_poison;
      logic err_malformed_sop;
      logic err_malformed_eop;
   } t_tlp_err;
endpackage

module pcie_rx_tlp_checker
   import pcie_rx_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  t_avst_pcie_rx rx_in,
   output t_avst_pcie_rx rx_out,
   output t_tlp_err      err_pulse,
   output t_tlp_err      err_sticky,
   input  logic          err_clear
);

   localparam logic [7:0] MAX_BEATS = 8'(PCIE_MAX_LEN / AVST_DWORD_LEN);

   typedef enum logic [1:0] {IDLE = 2'd0, PKT = 2'd1, DROP = 2'd2} t_state;

   t_state     state, state_next;
   logic [7:0] beat_cnt, beat_cnt_next, beat_cnt_inc;
   logic       fwd;
   t_tlp_err   err_next;

   logic [2:0] fmt;
   logic [4:0] tlp_type;
   logic       ep;
   logic       fmttype_ok;
   logic       poison;
   logic       sop_bad;

   assign fmt      = rx_in.hdr[127:125];
   assign tlp_type = rx_in.hdr[124:120];
   assign ep       = rx_in.hdr[110];
   assign poison   = fmt[1] & ep;
   assign sop_bad  = ~fmttype_ok | poison;

   always_comb begin
      fmttype_ok = 1'b0;
      casez ({fmt, tlp_type})
         8'b00?_00000: fmttype_ok = 1'b1;   // MRd 32/64
         8'b01?_00000: fmttype_ok = 1'b1;   // MWr 32/64
         8'b000_01010: fmttype_ok = 1'b1;   // Cpl
         8'b010_01010: fmttype_ok = 1'b1;   // CplD
         8'b0?1_10???: fmttype_ok = 1'b1;   // Msg / MsgD, any routing
         default:      fmttype_ok = 1'b0;
      endcase
   end

   // Saturating so a runaway packet cannot wrap the counter.
   assign beat_cnt_inc = (beat_cnt == MAX_BEATS) ? beat_cnt : beat_cnt + 8'd1;

`ifdef PCIE_RX_LEN_CHECK_EN
   logic [9:0]  len_raw;
   logic [10:0] len_dw;
   logic [10:0] len_round;
   logic [7:0]  exp_sop;
   logic [7:0]  exp_beats;

   assign len_raw   = rx_in.hdr[105:96];
   assign len_dw    = (len_raw == 10'd0) ? 11'(PCIE_MAX_LEN) : {1'b0, len_raw};
   assign len_round = len_dw + 11'd7;
   assign exp_sop   = fmt[1] ? len_round[10:3] : 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         exp_beats <= 8'd0;
      end else if (rx_in.valid && rx_in.sop && !sop_bad) begin
         exp_beats <= exp_sop;
      end
   end
`endif

   always_comb begin
      state_next    = state;
      beat_cnt_next = beat_cnt;
      fwd           = 1'b0;
      err_next      = '0;
      if (rx_in.valid) begin
         if (rx_in.sop) begin
            // A sop inside a packet aborts it and restarts decode on this beat.
            err_next.err_malformed_sop = (state != IDLE);
            err_next.err_fmttype       = ~fmttype_ok;
            err_next.err_poison        = poison;
            fwd                        = ~sop_bad;
            beat_cnt_next              = 8'd1;
            if (rx_in.eop) begin
               state_next = IDLE;
            end else begin
               state_next = sop_bad ? DROP : PKT;
            end
`ifdef PCIE_RX_LEN_CHECK_EN
            if (!sop_bad) begin
               err_next.err_malformed_eop = rx_in.eop ^ (exp_sop == 8'd1);
            end
`endif
         end else begin
            unique case (state)
               IDLE: begin
                  err_next.err_malformed_eop = rx_in.eop;
                  err_next.err_malformed_sop = ~rx_in.eop;
               end
               PKT: begin
                  fwd           = 1'b1;
                  beat_cnt_next = beat_cnt_inc;
                  if (rx_in.eop) begin
                     state_next = IDLE;
                  end
`ifdef PCIE_RX_LEN_CHECK_EN
                  if (rx_in.eop) begin
                     err_next.err_malformed_eop = (beat_cnt_inc != exp_beats) ||
                                                  (beat_cnt == MAX_BEATS);
                  end else begin
                     err_next.err_malformed_eop = (beat_cnt_inc == exp_beats) &&
                                                  (beat_cnt != exp_beats);
                  end
`endif
               end
               DROP: begin
                  beat_cnt_next = beat_cnt_inc;
                  if (rx_in.eop) begin
                     state_next = IDLE;
                  end
               end
               default: state_next = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         beat_cnt   <= 8'd0;
         rx_out     <= '0;
         err_pulse  <= '0;
         err_sticky <= '0;
      end else begin
         state        <= state_next;
         beat_cnt     <= beat_cnt_next;
         rx_out       <= rx_in;
         rx_out.valid <= fwd;
         err_pulse    <= err_next;
         err_sticky   <= err_clear ? t_tlp_err'('0) : t_tlp_err'(err_sticky | err_next);
      end
   end

endmodule

// File: tb/tb_pcie_rx_tlp_checker.sv
// Bench for pcie_rx_tlp_checker: directed vector table, multi-cycle corner sequences, random traffic vs packet model.
module tb_pcie_rx_tlp_checker;
   import pcie_rx_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   t_avst_pcie_rx rx_in;
   t_avst_pcie_rx rx_out;
   t_tlp_err      err_pulse;
   t_tlp_err      err_sticky;
   logic          err_clear;

   int checks   = 0;
   int failures = 0;

   localparam logic [3:0] E_NONE = 4'b0000;
   localparam logic [3:0] E_FMT  = 4'b1000;
   localparam logic [3:0] E_POI  = 4'b0100;
   localparam logic [3:0] E_MSOP = 4'b0010;
   localparam logic [3:0] E_MEOP = 4'b0001;

   pcie_rx_tlp_checker dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .rx_out     (rx_out),
      .err_pulse  (err_pulse),
      .err_sticky (err_sticky),
      .err_clear  (err_clear)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          v, s, e, clr;
      logic [31:0] dw0;
      bit          xv;
      logic [3:0]  xp, xs;
   } vec_t;

   vec_t        tv[$];
   logic [7:0]  legal_q[$];
   logic [255:0] sent_data;

   // reference model state: packet-level view of the stream
   bit         in_pkt;
   bit         pkt_fwd;
   int         pkt_beats;
   int         pkt_exp;
   logic [7:0] m_sticky;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_dw0(input logic [2:0] f, input logic [4:0] t,
                                          input bit epb, input logic [9:0] len);
      logic [31:0] d;
      d        = '0;
      d[31:29] = f;
      d[28:24] = t;
      d[14]    = epb;
      d[9:0]   = len;
      return d;
   endfunction

   function automatic bit is_legal(input logic [7:0] code);
      foreach (legal_q[i]) if (legal_q[i] == code) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int exp_beats_of(input logic [31:0] dw0);
      int l;
      l = (dw0[9:0] == 10'd0) ? 1024 : int'(dw0[9:0]);
      return dw0[30] ? (l + 7) / 8 : 1;
   endfunction

   task automatic put(input bit v, input bit s, input bit e, input logic [31:0] dw0, input bit clr);
      rx_in.valid     = v;
      rx_in.sop       = s;
      rx_in.eop       = e;
      rx_in.empty     = 3'($urandom);
      rx_in.bar_range = 3'($urandom);
      rx_in.hdr       = {dw0, $urandom, $urandom, $urandom};
      rx_in.data      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      err_clear       = clr;
      sent_data       = rx_in.data;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model(output bit ev, output logic [7:0] ep);
      logic [31:0] dw0;
      bit          legal, poisoned;
      ev  = 1'b0;
      ep  = '0;
      dw0 = rx_in.hdr[127:96];
      if (rx_in.valid) begin
         if (rx_in.sop) begin
            legal    = is_legal(dw0[31:24]);
            poisoned = dw0[30] && dw0[14];
            ep[1]    = in_pkt;
            ep[3]    = !legal;
            ep[2]    = poisoned;
            ev       = legal && !poisoned;
            in_pkt   = !rx_in.eop;
            pkt_fwd  = ev;
            pkt_beats = 1;
            pkt_exp  = exp_beats_of(dw0);
`ifdef PCIE_RX_LEN_CHECK_EN
            if (ev && (rx_in.eop ? (pkt_exp != 1) : (pkt_exp == 1))) ep[0] = 1'b1;
`endif
         end else if (!in_pkt) begin
            ep[0] = rx_in.eop;
            ep[1] = !rx_in.eop;
         end else begin
            pkt_beats++;
            ev = pkt_fwd;
`ifdef PCIE_RX_LEN_CHECK_EN
            if (pkt_fwd && (rx_in.eop ? (pkt_beats != pkt_exp) : (pkt_beats == pkt_exp))) ep[0] = 1'b1;
`endif
            if (rx_in.eop) in_pkt = 1'b0;
         end
      end
      m_sticky = err_clear ? 8'h00 : (m_sticky | ep);
   endtask

   task automatic rnd_beat(input bit v, input bit s, input bit e, input logic [31:0] dw0);
      bit         ev;
      logic [7:0] ep;
      put(v, s, e, dw0, ($urandom_range(0, 15) == 0));
      model(ev, ep);
      tick();
      chk("rnd_valid", rx_out.valid, ev);
      chk("rnd_pulse", 8'(err_pulse), ep);
      chk("rnd_sticky", 8'(err_sticky), m_sticky);
      if (ev) chk("rnd_data", rx_out.data, sent_data);
   endtask

   function automatic void add(input bit v, s, e, input logic [31:0] dw0, input bit clr,
                               input bit xv, input logic [3:0] xp, input logic [3:0] xs);
      vec_t r;
      r.v = v; r.s = s; r.e = e; r.dw0 = dw0; r.clr = clr;
      r.xv = xv; r.xp = xp; r.xs = xs;
      tv.push_back(r);
   endfunction

   initial begin
      logic [31:0] mwr16, mwr24, mwr32, mwr0, badft;
      int          fwd_cnt, err_seen, next_idx;
      logic [7:0]  code;
      logic [9:0]  len;
      int          nb;

      mwr16 = mk_dw0(3'b010, 5'b00000, 1'b0, 10'd16);
      mwr24 = mk_dw0(3'b010, 5'b00000, 1'b0, 10'd24);
      mwr32 = mk_dw0(3'b010, 5'b00000, 1'b0, 10'd32);
      mwr0  = mk_dw0(3'b010, 5'b00000, 1'b0, 10'd0);
      badft = mk_dw0(3'b010, 5'b00100, 1'b0, 10'd8);

      foreach (legal_q[i]) legal_q.delete(i);
      legal_q.push_back(8'b000_00000);
      legal_q.push_back(8'b001_00000);
      legal_q.push_back(8'b010_00000);
      legal_q.push_back(8'b011_00000);
      legal_q.push_back(8'b000_01010);
      legal_q.push_back(8'b010_01010);
      for (int r = 0; r < 8; r++) begin
         legal_q.push_back({3'b001, 2'b10, 3'(r)});
         legal_q.push_back({3'b011, 2'b10, 3'(r)});
      end

      //  v  s  e  dw0                                      clr xv  pulse          sticky
      add(1, 1, 0, mwr16,                                    0, 1, E_NONE, E_NONE);
      add(1, 0, 1, 32'h0,                                    0, 1, E_NONE, E_NONE);
      add(0, 0, 0, 32'h0,                                    0, 0, E_NONE, E_NONE);
      add(1, 1, 1, mk_dw0(3'b010, 5'b01010, 1'b1, 10'd4),    0, 0, E_POI,  E_POI);
      add(0, 0, 0, 32'h0,                                    0, 0, E_NONE, E_POI);
      add(0, 0, 0, 32'h0,                                    1, 0, E_NONE, E_NONE);
      add(1, 1, 0, badft,                                    0, 0, E_FMT,  E_FMT);
      add(1, 0, 0, 32'h0,                                    0, 0, E_NONE, E_FMT);
      add(1, 0, 1, 32'h0,                                    0, 0, E_NONE, E_FMT);
      add(1, 1, 1, mk_dw0(3'b000, 5'b00000, 1'b0, 10'd1),    0, 1, E_NONE, E_FMT);
      add(0, 0, 0, 32'h0,                                    1, 0, E_NONE, E_NONE);
      add(1, 1, 0, mwr32,                                    0, 1, E_NONE, E_NONE);
      add(1, 1, 0, mwr24,                                    0, 1, E_MSOP, E_MSOP);
      add(1, 0, 0, 32'h0,                                    0, 1, E_NONE, E_MSOP);
      add(1, 0, 1, 32'h0,                                    0, 1, E_NONE, E_MSOP);
      add(1, 0, 1, 32'h0,                                    0, 0, E_MEOP, E_MSOP | E_MEOP);
      add(1, 0, 0, 32'h0,                                    0, 0, E_MSOP, E_MSOP | E_MEOP);
      add(1, 0, 1, 32'h0,                                    1, 0, E_MEOP, E_NONE);
      add(0, 0, 0, 32'h0,                                    0, 0, E_NONE, E_NONE);
      add(1, 1, 1, mk_dw0(3'b001, 5'b10011, 1'b0, 10'd0),    0, 1, E_NONE, E_NONE);
      add(1, 1, 1, mk_dw0(3'b000, 5'b01010, 1'b1, 10'd1),    0, 1, E_NONE, E_NONE);
      add(1, 1, 1, mk_dw0(3'b011, 5'b10101, 1'b1, 10'd1),    0, 0, E_POI,  E_POI);
      add(1, 1, 1, mk_dw0(3'b001, 5'b01010, 1'b0, 10'd1),    0, 0, E_FMT,  E_POI | E_FMT);
      add(1, 1, 0, badft,                                    0, 0, E_FMT,  E_POI | E_FMT);
      add(1, 1, 0, mwr16,                                    0, 1, E_MSOP, E_POI | E_FMT | E_MSOP);
      add(1, 0, 1, 32'h0,                                    0, 1, E_NONE, E_POI | E_FMT | E_MSOP);
      add(0, 1, 1, badft,                                    0, 0, E_NONE, E_POI | E_FMT | E_MSOP);
      add(1, 1, 1, mk_dw0(3'b001, 5'b00000, 1'b0, 10'd2),    1, 1, E_NONE, E_NONE);

      rst = 1'b1;
      put(0, 0, 0, 32'h0, 0);
      tick();
      tick();
      chk("reset_valid", rx_out.valid, 1'b0);
      chk("reset_pulse", 8'(err_pulse), 8'h00);
      chk("reset_sticky", 8'(err_sticky), 8'h00);
      rst = 1'b0;

      foreach (tv[i]) begin
         put(tv[i].v, tv[i].s, tv[i].e, tv[i].dw0, tv[i].clr);
         tick();
         chk($sformatf("tv%0d_valid", i), rx_out.valid, tv[i].xv);
         chk($sformatf("tv%0d_pulse", i), 8'(err_pulse), {4'h0, tv[i].xp});
         chk($sformatf("tv%0d_sticky", i), 8'(err_sticky), {4'h0, tv[i].xs});
         if (tv[i].xv) chk($sformatf("tv%0d_data", i), rx_out.data, sent_data);
      end

      // 1024-DW write over 128 beats, valid on alternate cycles
      for (int pass = 0; pass < 2; pass++) begin
         int nbeats;
         nbeats   = (pass == 0) ? 128 : 127;
         fwd_cnt  = 0;
         err_seen = 0;
         next_idx = 0;
         for (int c = 0; c < 2 * nbeats; c++) begin
            if (c % 2 == 0) begin
               put(1, (c == 0), (c / 2 == nbeats - 1), mwr0, 0);
               rx_in.data[7:0] = 8'(c / 2);
            end else begin
               put(0, 0, 0, 32'h0, 0);
            end
            tick();
            if (rx_out.valid) begin
               if (rx_out.data[7:0] != 8'(next_idx)) err_seen++;
               next_idx++;
               fwd_cnt++;
            end
            if (c == 2 * nbeats - 2) begin
`ifdef PCIE_RX_LEN_CHECK_EN
               chk($sformatf("long%0d_eop_pulse", pass), 8'(err_pulse), (pass == 0) ? 8'h00 : 8'h01);
`else
               chk($sformatf("long%0d_eop_pulse", pass), 8'(err_pulse), 8'h00);
`endif
            end else if (8'(err_pulse) != 8'h00) begin
               err_seen++;
            end
         end
         chk($sformatf("long%0d_fwd_count", pass), fwd_cnt, nbeats);
         chk($sformatf("long%0d_order_and_quiet", pass), err_seen, 0);
         put(0, 0, 0, 32'h0, 1);
         tick();
      end

      // reset in the middle of a packet
      put(1, 0, 1, 32'h0, 0);
      tick();
      chk("pre_rst_sticky", 8'(err_sticky), 8'h01);
      put(1, 1, 0, mwr32, 0);
      tick();
      put(1, 0, 0, 32'h0, 0);
      tick();
      chk("pre_rst_fwd", rx_out.valid, 1'b1);
      rst = 1'b1;
      put(1, 0, 0, 32'h0, 0);
      tick();
      rst = 1'b0;
      chk("rst_mid_valid", rx_out.valid, 1'b0);
      chk("rst_mid_pulse", 8'(err_pulse), 8'h00);
      chk("rst_mid_sticky", 8'(err_sticky), 8'h00);
      put(1, 0, 0, 32'h0, 0);
      tick();
      chk("post_rst_mid_valid", rx_out.valid, 1'b0);
      chk("post_rst_mid_pulse", 8'(err_pulse), 8'h02);
      put(1, 0, 1, 32'h0, 0);
      tick();
      chk("post_rst_eop_valid", rx_out.valid, 1'b0);
      chk("post_rst_eop_pulse", 8'(err_pulse), 8'h01);

      // random traffic against the packet model
      rst = 1'b1;
      put(0, 0, 0, 32'h0, 0);
      tick();
      rst       = 1'b0;
      in_pkt    = 1'b0;
      pkt_fwd   = 1'b0;
      pkt_beats = 0;
      pkt_exp   = 0;
      m_sticky  = 8'h00;
      for (int it = 0; it < 600; it++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind < 7) begin
            code = ($urandom_range(0, 3) != 0) ? legal_q[$urandom_range(0, legal_q.size() - 1)]
                                               : 8'($urandom);
            nb = $urandom_range(1, 4);
            if (code[6] && $urandom_range(0, 1) == 1) begin
               len = 10'(nb * 8 - $urandom_range(0, 7));
            end else begin
               len = 10'($urandom);
               if (!code[6] && $urandom_range(0, 1) == 1) nb = 1;
            end
            for (int b = 0; b < nb; b++) begin
               if (b > 0 && $urandom_range(0, 2) == 0) begin
                  for (int g = 0; g < int'($urandom_range(1, 2)); g++)
                     rnd_beat(0, 1'($urandom), 1'($urandom), 32'($urandom));
               end
               rnd_beat(1, (b == 0), (b == nb - 1) && ($urandom_range(0, 9) != 0),
                        mk_dw0(code[7:5], code[4:0], ($urandom_range(0, 3) == 0), len));
            end
         end else if (kind == 7) begin
            rnd_beat(1, 0, 1'($urandom), 32'($urandom));
         end else begin
            rnd_beat(0, 1'($urandom), 1'($urandom), 32'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
